// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file constants and typedefs for the MIPS pipeline
package cpu_pkg;
  localparam int N_REG = 32;
  localparam int N_REG_ADDR = 5;
  localparam logic [N_REG_ADDR-1:0] NOP_REG_ADDR = '0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE = 1'b1;
  localparam logic READ_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD = '0;
  typedef logic [N_REG_ADDR-1:0] reg_addr_t;
  typedef logic [31:0] reg_data_t;
endpackage

// File: rtl/hilo_reg.sv
// hilo_reg: HI/LO storage with optional write-through bypass (WB_BYPASS_EN)
module hilo_reg import cpu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wen,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  logic [DATA_W-1:0] hi_q, lo_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (i_wen == WRITE_ENABLE) begin
      hi_q <= i_hi;
      lo_q <= i_lo;
    end
`ifdef WB_BYPASS_EN
  assign o_hi = i_wen ? i_hi : hi_q;
  assign o_lo = i_wen ? i_lo : lo_q;
`else
  assign o_hi = hi_q;
  assign o_lo = lo_q;
`endif
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: GPR file plus HI/LO write-back sink; WB_BYPASS_EN adds same-cycle write-through
module wb_regfile import cpu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_wen,
  input  logic [ADDR_W-1:0] i_wb_waddr,
  input  logic [DATA_W-1:0] i_wb_wdata,
  input  logic              i_wb_hilo_wen,
  input  logic [DATA_W-1:0] i_wb_hi,
  input  logic [DATA_W-1:0] i_wb_lo,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic hit1, hit2;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (i_wb_wen == WRITE_ENABLE && i_wb_waddr != NOP_REG_ADDR) begin
      regs[i_wb_waddr] <= i_wb_wdata;
    end
`ifdef WB_BYPASS_EN
  assign hit1 = i_wb_wen && i_wb_waddr == i_raddr1;
  assign hit2 = i_wb_wen && i_wb_waddr == i_raddr2;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  // r0 never reaches the array, so address 0 must be decoded before the lookup
  assign o_rdata1 = (i_re1 == READ_DISABLE || i_raddr1 == NOP_REG_ADDR) ? ZERO_WORD :
                    hit1 ? i_wb_wdata : regs[i_raddr1];
  assign o_rdata2 = (i_re2 == READ_DISABLE || i_raddr2 == NOP_REG_ADDR) ? ZERO_WORD :
                    hit2 ? i_wb_wdata : regs[i_raddr2];
  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_wen(i_wb_hilo_wen),
    .i_hi(i_wb_hi),
    .i_lo(i_wb_lo),
    .o_hi(o_hi),
    .o_lo(o_lo)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed checks of wb_regfile against an array model
module tb_wb_regfile;
  logic clk = 0, rst = 1;
  logic wen = 0, hwen = 0, re1 = 0, re2 = 0;
  logic [4:0] waddr = 0, ra1 = 0, ra2 = 0;
  logic [31:0] wdata = 0, whi = 0, wlo = 0;
  logic [31:0] rd1, rd2, ohi, olo;
  logic [31:0] mdl [32];
  logic [31:0] mhi, mlo;
  int n_tests = 0, n_fail = 0;

  wb_regfile dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_wen(wen), .i_wb_waddr(waddr), .i_wb_wdata(wdata),
    .i_wb_hilo_wen(hwen), .i_wb_hi(whi), .i_wb_lo(wlo),
    .i_re1(re1), .i_raddr1(ra1), .o_rdata1(rd1),
    .i_re2(re2), .i_raddr2(ra2), .o_rdata2(rd2),
    .o_hi(ohi), .o_lo(olo)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(logic re, logic [4:0] a);
    if (!re || a == 0) return 0;
`ifdef WB_BYPASS_EN
    if (wen && waddr == a) return wdata;
`endif
    return mdl[a];
  endfunction

  function automatic logic [31:0] exp_hi();
`ifdef WB_BYPASS_EN
    if (hwen) return whi;
`endif
    return mhi;
  endfunction

  function automatic logic [31:0] exp_lo();
`ifdef WB_BYPASS_EN
    if (hwen) return wlo;
`endif
    return mlo;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    mhi = 0;
    mlo = 0;
  endtask

  task automatic cyc();
    #1;
    check("rd1", rd1, exp_rd(re1, ra1));
    check("rd2", rd2, exp_rd(re2, ra2));
    check("hi", ohi, exp_hi());
    check("lo", olo, exp_lo());
    @(posedge clk);
    if (!rst) begin
      if (wen && waddr != 0) mdl[waddr] = wdata;
      if (hwen) begin
        mhi = whi;
        mlo = wlo;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    re1 = 1;
    re2 = 1;
    for (int c = 0; c < 40; c++) begin
      wen = 1;
      waddr = 5'($urandom);
      wdata = $urandom;
      hwen = 1'($urandom);
      whi = $urandom;
      wlo = $urandom;
      ra1 = 5'($urandom);
      ra2 = 5'($urandom);
      cyc();
    end
    rst = 1;
    clear_model();
    wen = 1; waddr = 5; wdata = 32'hCAFEF00D; hwen = 0;
    for (int a = 1; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(32 - a);
      #1;
      if (a != 5) check("t1_rst_rd1", rd1, 0);
      check("t1_rst_rd2", rd2, exp_rd(1, ra2));
    end
    check("t1_rst_hi", ohi, 0);
    check("t1_rst_lo", olo, 0);
    cyc();
    rst = 0; wen = 0; ra1 = 5; ra2 = 6;
    #1 check("t1_r5", rd1, 0);
    cyc();
    wen = 1; waddr = 5; wdata = 32'hDEADBEEF;
    cyc();
    wen = 0;
    #1 check("t2_r5", rd1, 32'hDEADBEEF);
    check("t2_r6", rd2, 0);
    cyc();
    wen = 1; waddr = 7; wdata = 32'h77;
    cyc();
    waddr = 0; wdata = 32'h12345678; ra1 = 0; ra2 = 0;
    cyc();
    wen = 0;
    #1 check("t3_r0_p1", rd1, 0);
    check("t3_r0_p2", rd2, 0);
    re1 = 0; ra1 = 7; ra2 = 7;
    #1 check("t3_re0", rd1, 0);
    check("t3_r7", rd2, 32'h77);
    cyc();
    re1 = 1;
    wen = 1; waddr = 9; wdata = 32'h1;
    cyc();
    wdata = 32'hA5A5A5A5; ra1 = 9; ra2 = 9;
`ifdef WB_BYPASS_EN
    #1 check("t4_same_p1", rd1, 32'hA5A5A5A5);
    check("t4_same_p2", rd2, 32'hA5A5A5A5);
`else
    #1 check("t4_same_p1", rd1, 32'h1);
    check("t4_same_p2", rd2, 32'h1);
`endif
    cyc();
    wen = 0;
    #1 check("t4_next", rd1, 32'hA5A5A5A5);
    cyc();
    hwen = 1; whi = 1; wlo = 2; wen = 1; waddr = 3; wdata = 3; ra1 = 3;
    cyc();
    hwen = 0; wen = 0; whi = 32'h99; wlo = 32'h98;
    #1 check("t5_hi", ohi, 1);
    check("t5_lo", olo, 2);
    check("t5_r3", rd1, 3);
    cyc();
    #1 check("t5_hold_hi", ohi, 1);
    check("t5_hold_lo", olo, 2);
    foreach (mdl[i]) if (i < 3) begin end
    ra1 = 31; ra2 = 31;
    for (int k = 1; k <= 3; k++) begin
      wen = 1; waddr = 31; wdata = 32'(k * 16);
      cyc();
    end
    wen = 0;
    #1 check("t6_final", rd1, 32'h30);
    cyc();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1;
        clear_model();
      end else rst = 0;
      wen = 1'($urandom);
      waddr = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
      wdata = $urandom;
      hwen = 1'($urandom);
      whi = $urandom;
      wlo = $urandom;
      re1 = $urandom_range(0, 7) != 0;
      re2 = $urandom_range(0, 7) != 0;
      ra1 = $urandom_range(0, 1) == 0 ? waddr : 5'($urandom_range(0, 7));
      ra2 = $urandom_range(0, 2) == 0 ? ra1 : 5'($urandom);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
